machine_timer_bank: RTL and testbench

Parametrised successor to the single mtime/mtimecmp pair in the top-level memory-mapped register decode. Provides one free-running machine timer with a programmable prescaler, CHANNEL_COUNT independent compare channels with a per-channel interrupt mask, and a consistent 64-bit read snapshot. Sits on the core's data-memory port in the clk24 domain, beside block RAM and the USB data buffer. Its registered read value is muxed into the core's read path.

---
 rtl/machine_timer_bank_pkg.sv | 33 +++
 rtl/machine_timer_bank_compare_channel.sv | 43 ++++
 rtl/machine_timer_bank.sv | 178 +++++++++++++++++
 tb/tb_machine_timer_bank.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/machine_timer_bank_pkg.sv
// Shared register-map constants and byte-lane helper for the machine timer bank.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package machine_timer_bank_pkg;

  // Byte offsets of each register word from the window base.
  localparam logic [31:0] OFFSET_MTIME_LO      = 32'h00;
  localparam logic [31:0] OFFSET_MTIME_HI      = 32'h04;
  localparam logic [31:0] OFFSET_MTIME_SNAP_HI = 32'h08;
  localparam logic [31:0] OFFSET_CONTROL       = 32'h0C;
  localparam logic [31:0] OFFSET_STATUS        = 32'h10;
  localparam logic [31:0] OFFSET_MTIMECMP_BASE = 32'h20;
  localparam int          CHANNEL_STRIDE       = 8;

  // CONTROL field positions. The divisor lives entirely in byte lane 1 and
  // the mask entirely in byte lane 2, since both are at most 8 bits wide.
  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_DIVISOR_LSB = 8;
  localparam int CTRL_MASK_LSB    = 16;

  // Replace only the byte lanes whose section bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_value,
                                              input logic [31:0] new_value,
                                              input logic [3:0]  sections);
    logic [31:0] merged;
    merged = old_value;
    for (int b = 0; b < 4; b++) begin
      if (sections[b]) merged[8*b +: 8] = new_value[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/machine_timer_bank_compare_channel.sv
// One compare channel: mtimecmp register with byte-lane writes, >= compare, mask gate.
// Latency: a write lands at the edge; the compare output follows combinationally from registers.
// Backpressure: none, every write is accepted in the cycle it is presented.
module timer_compare_channel
  import machine_timer_bank_pkg::*;
#(
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                     clk24,
  input  logic                     reset,
  input  logic                     write_lo,
  input  logic                     write_hi,
  input  logic [31:0]              write_value,
  input  logic [3:0]               write_sections,
  input  logic [COUNTER_WIDTH-1:0] mtime,
  input  logic                     mask_bit,
  output logic [63:0]              compare_readback,
  output logic                     raw_match,
  output logic                     interrupt
);

  logic [COUNTER_WIDTH-1:0] cmp_q, cmp_d;
  logic [63:0]              cmp_wide;

  // Merge the written half into a 64-bit view, then drop bits above the counter width.
  always_comb begin
    cmp_wide = 64'(cmp_q);
    if (write_lo) cmp_wide[31:0]  = merge_bytes(cmp_wide[31:0],  write_value, write_sections);
    if (write_hi) cmp_wide[63:32] = merge_bytes(cmp_wide[63:32], write_value, write_sections);
    cmp_d = COUNTER_WIDTH'(cmp_wide);
  end

  // All-ones out of reset keeps the channel quiet until software programs it.
  always_ff @(posedge clk24) begin
    if (reset) cmp_q <= '1;
    else       cmp_q <= cmp_d;
  end

  assign compare_readback = 64'(cmp_q);
  assign raw_match        = (mtime >= cmp_q);
  assign interrupt        = raw_match & mask_bit;

endmodule

// File: rtl/machine_timer_bank.sv
// Machine timer with prescaler, N masked compare channels and a 64-bit read snapshot.
// Latency: registered read data one cycle after the address, like block RAM.
// Backpressure: none, every access completes in the cycle it is presented.
module machine_timer_bank
  import machine_timer_bank_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'h8000_0000,
  parameter int          CHANNEL_COUNT  = 4,
  parameter int          COUNTER_WIDTH  = 64,
  parameter int          PRESCALE_WIDTH = 8
) (
  input  logic                     clk24,
  input  logic                     reset,
  input  logic [31:0]              memory_address,
  input  logic [31:0]              memory_write_value,
  input  logic [3:0]               memory_write_sections,
  output logic [31:0]              read_value,
  output logic                     read_selected,
  output logic [CHANNEL_COUNT-1:0] timer_interrupt,
  output logic                     mip_mtip
);

  localparam logic [29:0] WIN_FIRST = BASE_ADDRESS[31:2];
  localparam logic [29:0] WIN_LAST  = WIN_FIRST +
    30'((OFFSET_MTIMECMP_BASE + 32'(CHANNEL_STRIDE * CHANNEL_COUNT) - 32'd4) >> 2);

  logic                      hit, mem_write, mem_read;
  logic [29:0]               word_index;
  logic [31:0]               word_offset;
  logic                      wr_mtime_lo, wr_mtime_hi, wr_control;
  logic [CHANNEL_COUNT-1:0]  cmp_wr_lo, cmp_wr_hi, raw_match;
  logic [63:0]               cmp_readback [CHANNEL_COUNT];

  logic [COUNTER_WIDTH-1:0]  mtime_q, mtime_d;
  logic [PRESCALE_WIDTH-1:0] count_q, count_d;
  logic                      enable_q, enable_d;
  logic [PRESCALE_WIDTH-1:0] divisor_q, divisor_d;
  logic [CHANNEL_COUNT-1:0]  mask_q, mask_d;
  logic [31:0]               snapshot_q, snapshot_d;
  logic [31:0]               read_value_q, read_value_d;
  logic                      read_selected_q, read_selected_d;

  logic [63:0]               mtime_wide, mtime_write;
  logic [31:0]               control_word, read_word;

  // Address decode: window hit, word offset and per-register write strobes.
  always_comb begin
    hit         = (memory_address[31:2] >= WIN_FIRST) && (memory_address[31:2] <= WIN_LAST);
    word_index  = memory_address[31:2] - WIN_FIRST;
    word_offset = {word_index, 2'b00};
    mem_write   = hit && (memory_write_sections != 4'b0000);
    mem_read    = hit && (memory_write_sections == 4'b0000);
    wr_mtime_lo = mem_write && (word_offset == OFFSET_MTIME_LO);
    wr_mtime_hi = mem_write && (word_offset == OFFSET_MTIME_HI);
    wr_control  = mem_write && (word_offset == OFFSET_CONTROL);
    cmp_wr_lo   = '0;
    cmp_wr_hi   = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      cmp_wr_lo[i] = mem_write &&
        (word_offset == OFFSET_MTIMECMP_BASE + 32'(CHANNEL_STRIDE * i));
      cmp_wr_hi[i] = mem_write &&
        (word_offset == OFFSET_MTIMECMP_BASE + 32'(CHANNEL_STRIDE * i) + 32'd4);
    end
  end

  // Prescaled tick; a software write to mtime replaces the tick and restarts the prescaler.
  always_comb begin
    mtime_wide  = 64'(mtime_q);
    mtime_write = mtime_wide;
    mtime_d     = mtime_q;
    count_d     = count_q;
    if (enable_q) begin
      if (count_q == divisor_q) begin
        count_d = '0;
        mtime_d = mtime_q + COUNTER_WIDTH'(1);
      end else begin
        count_d = count_q + PRESCALE_WIDTH'(1);
      end
    end
    if (wr_mtime_lo)
      mtime_write[31:0]  = merge_bytes(mtime_wide[31:0],  memory_write_value, memory_write_sections);
    if (wr_mtime_hi)
      mtime_write[63:32] = merge_bytes(mtime_wide[63:32], memory_write_value, memory_write_sections);
    if (wr_mtime_lo || wr_mtime_hi) begin
      mtime_d = COUNTER_WIDTH'(mtime_write);
      count_d = '0;
    end
    if (wr_control) count_d = '0;
  end

  // CONTROL fields, each updated only by its own byte lane.
  always_comb begin
    enable_d  = enable_q;
    divisor_d = divisor_q;
    mask_d    = mask_q;
    if (wr_control) begin
      if (memory_write_sections[CTRL_ENABLE_BIT / 8])
        enable_d = memory_write_value[CTRL_ENABLE_BIT];
      if (memory_write_sections[CTRL_DIVISOR_LSB / 8])
        divisor_d = memory_write_value[CTRL_DIVISOR_LSB +: PRESCALE_WIDTH];
      if (memory_write_sections[CTRL_MASK_LSB / 8])
        mask_d = memory_write_value[CTRL_MASK_LSB +: CHANNEL_COUNT];
    end
  end

  // Readback mux over pre-edge state, plus the high-word snapshot taken on a low-word read.
  always_comb begin
    control_word = '0;
    control_word[CTRL_ENABLE_BIT]                   = enable_q;
    control_word[CTRL_DIVISOR_LSB +: PRESCALE_WIDTH] = divisor_q;
    control_word[CTRL_MASK_LSB +: CHANNEL_COUNT]     = mask_q;
    read_word = '0;
    case (word_offset)
      OFFSET_MTIME_LO:      read_word = mtime_wide[31:0];
      OFFSET_MTIME_HI:      read_word = mtime_wide[63:32];
      OFFSET_MTIME_SNAP_HI: read_word = snapshot_q;
      OFFSET_CONTROL:       read_word = control_word;
      OFFSET_STATUS:        read_word = 32'(raw_match);
      default: begin
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
          if (word_offset == OFFSET_MTIMECMP_BASE + 32'(CHANNEL_STRIDE * i))
            read_word = cmp_readback[i][31:0];
          if (word_offset == OFFSET_MTIMECMP_BASE + 32'(CHANNEL_STRIDE * i) + 32'd4)
            read_word = cmp_readback[i][63:32];
        end
      end
    endcase
    read_value_d    = hit ? read_word : 32'd0;
    read_selected_d = hit;
    snapshot_d      = (mem_read && (word_offset == OFFSET_MTIME_LO)) ? mtime_wide[63:32] : snapshot_q;
  end

  // State registers; reset wins over any write presented in the same cycle.
  always_ff @(posedge clk24) begin
    if (reset) begin
      mtime_q         <= '0;
      count_q         <= '0;
      enable_q        <= 1'b1;
      divisor_q       <= '0;
      mask_q          <= '1;
      snapshot_q      <= '0;
      read_value_q    <= '0;
      read_selected_q <= 1'b0;
    end else begin
      mtime_q         <= mtime_d;
      count_q         <= count_d;
      enable_q        <= enable_d;
      divisor_q       <= divisor_d;
      mask_q          <= mask_d;
      snapshot_q      <= snapshot_d;
      read_value_q    <= read_value_d;
      read_selected_q <= read_selected_d;
    end
  end

  for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_channel
    timer_compare_channel #(
      .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_channel (
      .clk24            (clk24),
      .reset            (reset),
      .write_lo         (cmp_wr_lo[g]),
      .write_hi         (cmp_wr_hi[g]),
      .write_value      (memory_write_value),
      .write_sections   (memory_write_sections),
      .mtime            (mtime_q),
      .mask_bit         (mask_q[g]),
      .compare_readback (cmp_readback[g]),
      .raw_match        (raw_match[g]),
      .interrupt        (timer_interrupt[g])
    );
  end

  assign read_value    = read_value_q;
  assign read_selected = read_selected_q;
  assign mip_mtip      = |timer_interrupt;

endmodule

// File: tb/tb_machine_timer_bank.sv
module tb_machine_timer_bank;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          CC   = 4;

  logic          clk24 = 1'b0;
  logic          reset;
  logic [31:0]   memory_address;
  logic [31:0]   memory_write_value;
  logic [3:0]    memory_write_sections;
  logic [31:0]   read_value;
  logic          read_selected;
  logic [CC-1:0] timer_interrupt;
  logic          mip_mtip;

  always #5 clk24 = ~clk24;

  machine_timer_bank #(
    .BASE_ADDRESS   (BASE),
    .CHANNEL_COUNT  (CC),
    .COUNTER_WIDTH  (64),
    .PRESCALE_WIDTH (8)
  ) dut (
    .clk24                 (clk24),
    .reset                 (reset),
    .memory_address        (memory_address),
    .memory_write_value    (memory_write_value),
    .memory_write_sections (memory_write_sections),
    .read_value            (read_value),
    .read_selected         (read_selected),
    .timer_interrupt       (timer_interrupt),
    .mip_mtip              (mip_mtip)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: architectural state of the register file.
  logic [63:0]   m_mtime;
  int unsigned   m_count;
  logic          m_en;
  logic [7:0]    m_div;
  logic [CC-1:0] m_mask;
  logic [63:0]   m_cmp [CC];
  logic [31:0]   m_snap;
  logic [31:0]   m_rv;
  logic          m_rs;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function logic [CC-1:0] m_raw();
    logic [CC-1:0] r;
    for (int i = 0; i < CC; i++) r[i] = (m_mtime >= m_cmp[i]);
    return r;
  endfunction

  function logic [31:0] m_ctrl();
    return {8'h00, 4'h0, m_mask, m_div, 7'h00, m_en};
  endfunction

  function logic [31:0] m_read(input logic [31:0] off);
    if (off == 32'h00) return m_mtime[31:0];
    if (off == 32'h04) return m_mtime[63:32];
    if (off == 32'h08) return m_snap;
    if (off == 32'h0C) return m_ctrl();
    if (off == 32'h10) return 32'(m_raw());
    if (off >= 32'h20 && off < 32'h20 + 32'(8 * CC)) begin
      int idx;
      idx = int'((off - 32'h20) / 8);
      return off[2] ? m_cmp[idx][63:32] : m_cmp[idx][31:0];
    end
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [31:0] a, input logic [31:0] wv, input logic [3:0] sec, input logic rst);
    logic        hit, wr;
    logic [31:0] off, img;
    logic [63:0] nm;
    int unsigned nc;
    if (rst) begin
      m_mtime = 64'd0; m_count = 0; m_en = 1'b1; m_div = 8'd0; m_mask = '1;
      for (int i = 0; i < CC; i++) m_cmp[i] = '1;
      m_snap = 32'd0; m_rv = 32'd0; m_rs = 1'b0;
      return;
    end
    hit = (a >= BASE) && (a < BASE + 32'h20 + 32'(8 * CC));
    off = (a - BASE) & 32'hFFFF_FFFC;
    wr  = hit && (sec != 4'b0000);
    nm  = m_mtime;
    nc  = m_count;
    if (m_en) begin
      if (nc == 32'(m_div)) begin nc = 0; nm = m_mtime + 64'd1; end
      else nc = nc + 1;
    end
    if (wr && off == 32'h00) begin nm = {m_mtime[63:32], merge(m_mtime[31:0], wv, sec)}; nc = 0; end
    if (wr && off == 32'h04) begin nm = {merge(m_mtime[63:32], wv, sec), m_mtime[31:0]}; nc = 0; end
    m_rv = hit ? m_read(off) : 32'd0;
    m_rs = hit;
    if (hit && sec == 4'b0000 && off == 32'h00) m_snap = m_mtime[63:32];
    if (wr && off == 32'h0C) begin
      nc = 0;
      img = merge(m_ctrl(), wv, sec);
      m_en = img[0]; m_div = img[15:8]; m_mask = img[16 +: CC];
    end
    if (wr && off >= 32'h20 && off < 32'h20 + 32'(8 * CC)) begin
      int idx;
      idx = int'((off - 32'h20) / 8);
      if (off[2]) m_cmp[idx][63:32] = merge(m_cmp[idx][63:32], wv, sec);
      else        m_cmp[idx][31:0]  = merge(m_cmp[idx][31:0],  wv, sec);
    end
    m_mtime = nm;
    m_count = nc;
  endtask

  // One clock: drive, advance the model, then check every output after the edge.
  task automatic step(input logic [31:0] a, input logic [31:0] wv, input logic [3:0] sec, input logic rst);
    memory_address        = a;
    memory_write_value    = wv;
    memory_write_sections = sec;
    reset                 = rst;
    model_step(a, wv, sec, rst);
    @(posedge clk24);
    #1;
    chk("read_value", 64'(read_value), 64'(m_rv));
    chk("read_selected", 64'(read_selected), 64'(m_rs));
    chk("timer_interrupt", 64'(timer_interrupt), 64'(m_raw() & m_mask));
    chk("mip_mtip", 64'(mip_mtip), 64'(|(m_raw() & m_mask)));
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] v);
    step(BASE + off, v, 4'hF, 1'b0);
  endtask

  task automatic rd(input logic [31:0] off);
    step(BASE + off, 32'd0, 4'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(32'h0000_0000, 32'd0, 4'h0, 1'b0);
  endtask

  logic [31:0] a0, a1;

  initial begin
    // Reset, then five idle cycles.
    step(32'h0, 32'd0, 4'h0, 1'b1);
    chk("reset_read_selected", 64'(read_selected), 64'd0);
    chk("reset_irq", 64'(timer_interrupt), 64'd0);
    idle(5);
    rd(32'h00);
    chk("mtime_after_5", 64'(read_value), 64'd5);
    rd(32'h0C);
    chk("control_reset", 64'(read_value), 64'h000F_0001);
    chk("mip_after_reset", 64'(mip_mtip), 64'd0);

    // Prescaler divisor 3, then divisor 0.
    wr(32'h0C, 32'h000F_0301);
    rd(32'h00); a0 = read_value;
    idle(11);
    rd(32'h00); a1 = read_value;
    chk("prescale_div3_delta", 64'(a1 - a0), 64'd3);
    wr(32'h0C, 32'h000F_0001);
    rd(32'h00); a0 = read_value;
    rd(32'h00); a1 = read_value;
    chk("prescale_div0_delta", 64'(a1 - a0), 64'd1);

    // Wrap from all ones; reset-value compares fire at all ones only.
    wr(32'h04, 32'hFFFF_FFFF);
    wr(32'h00, 32'hFFFF_FFFE);
    chk("irq_before_allones", 64'(timer_interrupt), 64'd0);
    idle(1);
    chk("irq_at_allones", 64'(timer_interrupt), 64'hF);
    chk("mip_at_allones", 64'(mip_mtip), 64'd1);
    idle(1);
    chk("irq_after_wrap", 64'(timer_interrupt), 64'd0);
    rd(32'h00);
    chk("mtime_lo_wrapped", 64'(read_value), 64'd0);
    rd(32'h04);
    chk("mtime_hi_wrapped", 64'(read_value), 64'd0);

    // Channel 2 compare at 100.
    wr(32'h34, 32'hFFFF_FFFF);
    wr(32'h30, 32'd100);
    wr(32'h34, 32'd0);
    wr(32'h04, 32'd0);
    wr(32'h00, 32'd90);
    idle(9);
    chk("ch2_before_100", 64'(timer_interrupt[2]), 64'd0);
    idle(1);
    chk("ch2_at_100", 64'(timer_interrupt[2]), 64'd1);
    chk("mip_at_100", 64'(mip_mtip), 64'd1);
    wr(32'h0C, 32'h000B_0001);
    chk("ch2_masked", 64'(timer_interrupt[2]), 64'd0);
    chk("mip_masked", 64'(mip_mtip), 64'd0);
    rd(32'h10);
    chk("status_raw_masked", 64'(read_value), 64'h4);
    wr(32'h30, 32'd1000);
    rd(32'h10);
    chk("status_after_raise", 64'(read_value), 64'h0);
    wr(32'h0C, 32'h000F_0001);

    // Snapshot across a carry into the high word.
    wr(32'h04, 32'h0000_0001);
    wr(32'h00, 32'hFFFF_FFFF);
    rd(32'h00);
    chk("snap_lo", 64'(read_value), 64'hFFFF_FFFF);
    rd(32'h08);
    chk("snap_hi", 64'(read_value), 64'h1);
    rd(32'h04);
    chk("live_hi", 64'(read_value), 64'h2);

    // Byte-lane write to MTIME_LO replaces the tick.
    wr(32'h00, 32'h1122_3344);
    step(BASE, 32'h0000_AB00, 4'b0010, 1'b0);
    rd(32'h00);
    chk("byte_write_lo", 64'(read_value), 64'h1122_AB44);

    // Reset beats a same-cycle write.
    step(BASE, 32'h1234_5678, 4'hF, 1'b1);
    rd(32'h00);
    chk("reset_over_write", 64'(read_value), 64'd0);

    // Unmapped in-window and out-of-window reads.
    rd(32'h18);
    chk("unmapped_rv", 64'(read_value), 64'd0);
    chk("unmapped_sel", 64'(read_selected), 64'd1);
    step(BASE - 32'd4, 32'd0, 4'h0, 1'b0);
    chk("outside_sel", 64'(read_selected), 64'd0);
    step(BASE + 32'h40, 32'd0, 4'h0, 1'b0);
    chk("past_end_sel", 64'(read_selected), 64'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, v;
      logic [3:0]  s;
      logic        r;
      int unsigned pick;
      pick = $urandom_range(0, 19);
      if (pick == 0)      a = BASE + 32'h40 + ($urandom_range(0, 3) << 2);
      else if (pick == 1) a = BASE - 32'd4;
      else if (pick < 5)  a = BASE + 32'h00;
      else                a = BASE + ($urandom_range(0, 15) << 2);
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      v = $urandom;
      if (a == BASE + 32'h0C && $urandom_range(0, 3) != 0) v[0] = 1'b1;
      if (a == BASE + 32'h0C) v[15:8] = 8'($urandom_range(0, 3));
      if ((a == BASE + 32'h04 || a[2] == 1'b1) && $urandom_range(0, 1) == 0) v = 32'd0;
      r = ($urandom_range(0, 99) == 0);
      step(a, v, s, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
